// File: rtl/mant_div_seq.sv
// Sequential restoring divider for normalized mantissas: one quotient bit per clock, QW = MW+2 bits.
// Optional MANT_DIV_EARLY_TERM_EN: finish as soon as the partial remainder reaches zero.
module mant_div_seq #(
    parameter int MW = 24
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [MW-1:0]   dividend,
    input  logic [MW-1:0]   divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [MW+1:0]   quotient,
    output logic            sticky,
    output logic            dz,
    output logic [1:0]      state_dbg
);

    localparam int QW = MW + 2;
    localparam int CW = $clog2(QW);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // out_valid stays high and the result stays stable until out_ready retires it.

    logic [1:0]    state;
    logic [MW-1:0] d_reg;
    logic [MW:0]   r_reg;
    logic [QW-1:0] q_reg;
    logic [CW-1:0] cnt;
    logic          sticky_reg;
    logic          dz_reg;

    logic [MW+2:0] sum;
    logic          no_borrow;
    logic [MW:0]   r_next;
    logic [QW-1:0] q_shift;
    logic [CW-1:0] shamt;
    logic          last_iter;
    logic          early_done;
    logic          finish;
    logic          unused_bits;

    // R - D at MW+2 bits as R + ~D + 1; the carry out of that width means no borrow.
    always_comb begin
        sum        = {2'b00, r_reg} + {1'b0, 2'b11, ~d_reg} + {{(MW+2){1'b0}}, 1'b1};
        no_borrow  = sum[MW+2];
        r_next     = no_borrow ? {sum[MW-1:0], 1'b0} : {r_reg[MW-1:0], 1'b0};
        q_shift    = {q_reg[QW-2:0], no_borrow};
        last_iter  = (cnt == CW'(QW - 1));
        shamt      = CW'(QW - 1) - cnt;
`ifdef MANT_DIV_EARLY_TERM_EN
        early_done = (r_next == '0);
`else
        early_done = 1'b0;
`endif
        finish     = last_iter || early_done;
    end

    // The difference is always below D, so its top two bits carry no information.
    assign unused_bits = &{1'b0, sum[MW+1:MW]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            d_reg      <= '0;
            r_reg      <= '0;
            q_reg      <= '0;
            cnt        <= '0;
            sticky_reg <= 1'b0;
            dz_reg     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        d_reg      <= divisor;
                        r_reg      <= {1'b0, dividend};
                        cnt        <= '0;
                        sticky_reg <= 1'b0;
                        if (!divisor[MW-1]) begin
                            dz_reg <= 1'b1;
                            q_reg  <= '1;
                            state  <= S_DONE;
                        end else begin
                            dz_reg <= 1'b0;
                            q_reg  <= '0;
                            state  <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_reg <= r_next;
                    cnt   <= cnt + CW'(1);
                    if (finish) begin
                        // Zero-fill the bits not yet produced; shamt is 0 on the last iteration.
                        q_reg      <= q_shift << shamt;
                        sticky_reg <= |r_next;
                        state      <= S_DONE;
                    end else begin
                        q_reg <= q_shift;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign quotient  = q_reg;
    assign sticky    = sticky_reg;
    assign dz        = dz_reg;
    assign state_dbg = state;

endmodule

// File: tb/tb_mant_div_seq.sv
// Directed, table-driven bench for mant_div_seq (MW=24, QW=26), including hold, ignore and reset-abort sequences.
module tb_mant_div_seq;

    localparam int MW = 24;
    localparam int QW = MW + 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [MW-1:0]   dividend = '0;
    logic [MW-1:0]   divisor = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [QW-1:0]   quotient;
    logic            sticky;
    logic            dz;
    logic [1:0]      state_dbg;

    int n_pass  = 0;
    int n_total = 0;
    logic [QW-1:0] exp_q[$];

    mant_div_seq #(.MW(MW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .sticky    (sticky),
        .dz        (dz),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [MW-1:0] a;
        logic [MW-1:0] b;
        logic [QW-1:0] q;
        logic          st;
        logic          dz;
        int            lat;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Present operands for one edge and count edges (accept edge = 1) until out_valid is seen.
    task automatic start_div(input logic [MW-1:0] a, input logic [MW-1:0] b,
                             input logic [QW-1:0] q_exp, output int lat);
        @(negedge clk);
        check("in_ready_before_accept", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        exp_q.push_back(q_exp);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        forever begin
            @(negedge clk);
            if (out_valid) break;
            if (lat >= 100) begin
                lat = -1;
                break;
            end
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input logic st_exp, input logic dz_exp);
        logic [QW-1:0] q_exp;
        q_exp = exp_q.pop_front();
        check({tag, "_quotient"}, 64'(quotient), 64'(q_exp));
        check({tag, "_sticky"},   64'(sticky),   64'(st_exp));
        check({tag, "_dz"},       64'(dz),       64'(dz_exp));
        check({tag, "_in_ready_low"}, 64'(in_ready), 64'd0);
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("retire_in_ready", 64'(in_ready), 64'd1);
        check("retire_out_valid", 64'(out_valid), 64'd0);
    endtask

    initial begin
        int lat;
        logic [QW-1:0] held_q;
        logic          held_st;

        // 0xFFFFFF/0x800000 = 2 - 2^-23: 24 ones followed by two zero bits.
`ifdef MANT_DIV_EARLY_TERM_EN
        vecs[0] = '{24'hC00000, 24'h800000, 26'h3000000, 1'b0, 1'b0, 3};
        vecs[1] = '{24'h800000, 24'hC00000, 26'h1555555, 1'b1, 1'b0, 27};
        vecs[2] = '{24'h800000, 24'h800000, 26'h2000000, 1'b0, 1'b0, 2};
        vecs[3] = '{24'hFFFFFF, 24'h800000, 26'h3FFFFFC, 1'b0, 1'b0, 25};
        vecs[4] = '{24'hABCDEF, 24'h000000, 26'h3FFFFFF, 1'b0, 1'b1, 1};
        vecs[5] = '{24'hFFFFFF, 24'hFFFFFF, 26'h2000000, 1'b0, 1'b0, 2};
        vecs[6] = '{24'hA00000, 24'h800000, 26'h2800000, 1'b0, 1'b0, 4};
        vecs[7] = '{24'h912345, 24'h7FFFFF, 26'h3FFFFFF, 1'b0, 1'b1, 1};
`else
        vecs[0] = '{24'hC00000, 24'h800000, 26'h3000000, 1'b0, 1'b0, 27};
        vecs[1] = '{24'h800000, 24'hC00000, 26'h1555555, 1'b1, 1'b0, 27};
        vecs[2] = '{24'h800000, 24'h800000, 26'h2000000, 1'b0, 1'b0, 27};
        vecs[3] = '{24'hFFFFFF, 24'h800000, 26'h3FFFFFC, 1'b0, 1'b0, 27};
        vecs[4] = '{24'hABCDEF, 24'h000000, 26'h3FFFFFF, 1'b0, 1'b1, 1};
        vecs[5] = '{24'hFFFFFF, 24'hFFFFFF, 26'h2000000, 1'b0, 1'b0, 27};
        vecs[6] = '{24'hA00000, 24'h800000, 26'h2800000, 1'b0, 1'b0, 27};
        vecs[7] = '{24'h912345, 24'h7FFFFF, 26'h3FFFFFF, 1'b0, 1'b1, 1};
`endif

        // Clock/reset block
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready",  64'(in_ready),  64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_quotient",  64'(quotient),  64'd0);
        check("reset_sticky",    64'(sticky),    64'd0);
        check("reset_dz",        64'(dz),        64'd0);

        for (int i = 0; i < 8; i++) begin
            start_div(vecs[i].a, vecs[i].b, vecs[i].q, lat);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            check_result($sformatf("vec%0d", i), vecs[i].st, vecs[i].dz);
            retire();
        end

        // Result held while out_ready stays low; in_valid pulses are ignored.
        start_div(24'h800000, 24'hC00000, 26'h1555555, lat);
        check("hold_latency", 64'(lat), 64'd27);
        held_q  = quotient;
        held_st = sticky;
        check_result("hold", 1'b1, 1'b0);
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            dividend = 24'h800000 | 24'($urandom_range(0, 24'h7FFFFF));
            divisor  = 24'h800000 | 24'($urandom_range(0, 24'h7FFFFF));
            @(posedge clk);
            @(negedge clk);
            check("hold_quotient",  64'(quotient),  64'(held_q));
            check("hold_sticky",    64'(sticky),    64'(held_st));
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_in_ready",  64'(in_ready),  64'd0);
        end
        in_valid = 1'b0;
        retire();

        // Reset during iteration 10 discards the division.
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 24'h800000;
        divisor  = 24'hC00000;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_in_ready",  64'(in_ready),  64'd1);
        check("abort_quotient",  64'(quotient),  64'd0);
        check("abort_sticky",    64'(sticky),    64'd0);

        start_div(vecs[0].a, vecs[0].b, vecs[0].q, lat);
        check("rerun_latency", 64'(lat), 64'(vecs[0].lat));
        check_result("rerun", 1'b0, 1'b0);
        retire();

        check("exp_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
